pc_push_unit: RTL and testbench
===============================

PC_PUSH_UNIT -- requirements
Module: pc_push_unit

Interface
REQ-001 Parameter ADDR_W, default 20: data-memory address width.
REQ-002 Parameter DATA_W, default 16: data-memory word width; the pushed PC is 2*DATA_W = 32 bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 push_req  input  1  request to push a return address (CALL or interrupt).
REQ-006 push_flags  input  1  qualifies push_req; when high, a flags word is also pushed (interrupt entry).
REQ-007 push_addr  input  32  return address to push.
REQ-008 flags_in  input  4  CCR flags to push, zero-extended to DATA_W.
REQ-009 sp  input  32  current stack pointer, pointing at the next free word.
REQ-010 mem_wr  output  1  data-memory write strobe.
REQ-011 mem_addr  output  ADDR_W  write address.
REQ-012 mem_data  output  DATA_W  write data.
REQ-013 sp_wr  output  1  one-cycle strobe to load sp_new into the SP register.
REQ-014 sp_new  output  32  updated stack pointer.
REQ-015 busy  output  1  push in progress; fetch holds pc_enable low while busy is set.
REQ-016 done  output  1  one-cycle pulse after the last word is written.

Function
REQ-017 States SHALL be: IDLE, PUSH_HI, PUSH_LO, PUSH_FL, FINISH.
REQ-018 In IDLE, a sampled push_req=1 SHALL latch push_addr, flags_in, push_flags and sp, then enter PUSH_HI.
REQ-019 Outputs SHALL be registered (Moore): mem_wr is high exactly in PUSH_HI, PUSH_LO and PUSH_FL, one word per cycle.
REQ-020 PUSH_HI: mem_addr=sp_l[ADDR_W-1:0], mem_data=addr_l[31:16].
REQ-021 PUSH_LO: mem_addr=(sp_l-1)[ADDR_W-1:0], mem_data=addr_l[15:0].
REQ-022 PUSH_FL, entered from PUSH_LO only if flags were latched: mem_addr=(sp_l-2)[ADDR_W-1:0], mem_data={12'b0, flags_l}.
REQ-023 Word order SHALL be high, then low, then flags, so that a pop of flags, then low, then high restores the original state.
REQ-024 FINISH: done=1 and sp_wr=1 for one cycle, sp_new=sp_l-2 or sp_l-3 (with flags); then return to IDLE.
REQ-025 SP arithmetic SHALL be modulo 2^32, and addresses SHALL be the low ADDR_W bits (sp=0 wraps to 0xFFFFFFFF / 0xFFFFF).
REQ-026 busy SHALL be high in every state other than IDLE.
REQ-027 push_req while busy SHALL be ignored, with no queueing; a new request is accepted in the first IDLE cycle after FINISH.
REQ-028 Input changes after acceptance SHALL NOT affect the sequence in progress.
REQ-029 Latency: req sampled at edge N gives the first write at edge N+2, done at N+3 (N+4 with flags).
REQ-030 In IDLE, mem_wr, sp_wr and done SHALL be 0; mem_addr and mem_data hold 0.

Reset
REQ-031 rst low SHALL immediately force IDLE and clear all outputs and latched registers to 0, regardless of clock.
REQ-032 Reset mid-sequence SHALL abort the push, with no further mem_wr and no sp_wr; a partially written stack is the caller's concern.
REQ-033 The first push_req is sampled at the first rising edge after rst deasserts.

Structure
REQ-034 State encoding, the word-count constants (2 and 3) and ADDR_W/DATA_W defaults SHALL live in the shared processor package.
REQ-035 No sub-module is required; a single FSM with a datapath register set is sufficient.

Verification
REQ-036 sp=0x000FFFFE, push_addr=0x00123456, push_flags=0, one-cycle req: writes (FFFFE,0x0012), (FFFFD,0x3456); sp_new=0x000FFFFC; done once.
REQ-037 Same but push_flags=1, flags_in=4'b1011: third write (FFFFC,0x000B); sp_new=0x000FFFFB; busy high 4 cycles.
REQ-038 sp=0x00000001, no flags: writes at 0x00001, 0x00000; sp_new=0xFFFFFFFF.
REQ-039 Second push_req asserted during PUSH_LO, and push_addr changed mid-sequence: exactly 2 writes carrying the original data; a new request held high is accepted after FINISH.
REQ-040 rst pulled low during PUSH_LO: mem_wr and busy drop at once, no sp_wr or done; the next request after reset completes normally.
REQ-041 Back-to-back requests held high continuously: sequences separated by exactly one IDLE cycle; sp_new reflects sp input as sampled at each acceptance.

Source files
------------

// File: rtl/pc_push_unit_pkg.sv
// Shared processor definitions for the PC push sequencer: state encoding,
// word counts, default memory geometry and stack-pointer arithmetic.
package pc_push_unit_pkg;

    localparam int unsigned PUSH_ADDR_W_DEFAULT = 20;
    localparam int unsigned PUSH_DATA_W_DEFAULT = 16;
    localparam int unsigned PUSH_FLAGS_W        = 4;

    // Words pushed for a plain CALL and for interrupt entry (PC + flags)
    localparam int unsigned PUSH_WORDS_PC       = 2;
    localparam int unsigned PUSH_WORDS_PC_FLAGS = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH_HI = 3'd1,
        ST_PUSH_LO = 3'd2,
        ST_PUSH_FL = 3'd3,
        ST_FINISH  = 3'd4
    } push_state_e;

    // Stack grows downward; arithmetic wraps modulo 2^32
    function automatic logic [31:0] sp_minus(input logic [31:0] sp_val,
                                             input int unsigned words);
        return sp_val - 32'(words);
    endfunction

endpackage

// File: rtl/pc_push_unit.sv
// PC push sequencer: writes a 32-bit return address (and optionally the CCR
// flags) onto the downward-growing data stack, one word per cycle, then
// strobes the updated stack pointer back to the SP register.
module pc_push_unit
    import pc_push_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = PUSH_ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = PUSH_DATA_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_req,
    input  logic                    push_flags,
    input  logic [2*DATA_W-1:0]     push_addr,
    input  logic [PUSH_FLAGS_W-1:0] flags_in,
    input  logic [31:0]             sp,
    output logic                    mem_wr,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_data,
    output logic                    sp_wr,
    output logic [31:0]             sp_new,
    output logic                    busy,
    output logic                    done
);

    push_state_e state, state_next;

    // Request operands captured at acceptance
    logic [2*DATA_W-1:0]     addr_l;
    logic [PUSH_FLAGS_W-1:0] flags_l;
    logic                    with_flags_l;
    logic [31:0]             sp_l;

    // Next values for the registered outputs
    logic                    mem_wr_d;
    logic [ADDR_W-1:0]       mem_addr_d;
    logic [DATA_W-1:0]       mem_data_d;
    logic                    sp_wr_d;
    logic [31:0]             sp_new_d;
    logic                    busy_d;
    logic                    done_d;

    logic accept;

    assign accept = (state == ST_IDLE) && push_req;

    // State register and operand capture; requests outside IDLE are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            addr_l       <= '0;
            flags_l      <= '0;
            with_flags_l <= 1'b0;
            sp_l         <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_l       <= push_addr;
                flags_l      <= flags_in;
                with_flags_l <= push_flags;
                sp_l         <= sp;
            end
        end
    end

    // Next-state and output decode of the current state
    always_comb begin
        state_next = state;
        mem_wr_d   = 1'b0;
        mem_addr_d = '0;
        mem_data_d = '0;
        sp_wr_d    = 1'b0;
        sp_new_d   = '0;
        busy_d     = (state != ST_IDLE);
        done_d     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (push_req) begin
                    state_next = ST_PUSH_HI;
                end
            end
            ST_PUSH_HI: begin
                mem_wr_d   = 1'b1;
                mem_addr_d = sp_l[ADDR_W-1:0];
                mem_data_d = addr_l[2*DATA_W-1:DATA_W];
                state_next = ST_PUSH_LO;
            end
            ST_PUSH_LO: begin
                mem_wr_d   = 1'b1;
                mem_addr_d = sp_l[ADDR_W-1:0] - ADDR_W'(1);
                mem_data_d = addr_l[DATA_W-1:0];
                state_next = with_flags_l ? ST_PUSH_FL : ST_FINISH;
            end
            ST_PUSH_FL: begin
                mem_wr_d   = 1'b1;
                mem_addr_d = sp_l[ADDR_W-1:0] - ADDR_W'(2);
                mem_data_d = DATA_W'(flags_l);
                state_next = ST_FINISH;
            end
            ST_FINISH: begin
                done_d     = 1'b1;
                sp_wr_d    = 1'b1;
                sp_new_d   = sp_minus(sp_l, with_flags_l ? PUSH_WORDS_PC_FLAGS
                                                         : PUSH_WORDS_PC);
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered Moore outputs: each strobe trails its state by one clock,
    // so a request sampled at edge N writes its first word at edge N+2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            sp_wr    <= 1'b0;
            sp_new   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            mem_wr   <= mem_wr_d;
            mem_addr <= mem_addr_d;
            mem_data <= mem_data_d;
            sp_wr    <= sp_wr_d;
            sp_new   <= sp_new_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_pc_push_unit.sv
// Scoreboard bench for pc_push_unit: expected stack writes and SP updates are
// queued when a request is driven and compared as the DUT emits them.
module tb_pc_push_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push_req = 1'b0;
    logic        push_flags = 1'b0;
    logic [31:0] push_addr = '0;
    logic [3:0]  flags_in = '0;
    logic [31:0] sp = '0;
    logic        mem_wr;
    logic [19:0] mem_addr;
    logic [15:0] mem_data;
    logic        sp_wr;
    logic [31:0] sp_new;
    logic        busy;
    logic        done;

    pc_push_unit #(.ADDR_W(20), .DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_req   (push_req),
        .push_flags (push_flags),
        .push_addr  (push_addr),
        .flags_in   (flags_in),
        .sp         (sp),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .sp_wr      (sp_wr),
        .sp_new     (sp_new),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_sp[$];
    wr_t         got_exp;
    logic [31:0] got_sp;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_seq    = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference model of one push: stack writes high, low, flags, then SP
    task automatic expect_push(input logic [31:0] s, input logic [31:0] a,
                               input logic f, input logic [3:0] fl);
        logic [31:0] s1, s2, s3;
        s1 = s - 32'd1;
        s2 = s - 32'd2;
        s3 = s - 32'd3;
        exp_wr.push_back('{addr: s[19:0],  data: a[31:16]});
        exp_wr.push_back('{addr: s1[19:0], data: a[15:0]});
        if (f) begin
            exp_wr.push_back('{addr: s2[19:0], data: {12'h000, fl}});
            exp_sp.push_back(s3);
        end else begin
            exp_sp.push_back(s2);
        end
        n_seq++;
    endtask

    // Monitor: compare every write strobe and SP strobe against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (mem_wr) begin
                if (exp_wr.size() > 0) begin
                    got_exp = exp_wr.pop_front();
                    check_eq("wr_addr", 32'(mem_addr), 32'(got_exp.addr));
                    check_eq("wr_data", 32'(mem_data), 32'(got_exp.data));
                end else begin
                    check_eq("wr_unexpected", 32'(mem_wr), 32'd0);
                end
            end else if (!busy) begin
                check_eq("idle_addr", 32'(mem_addr), 32'd0);
                check_eq("idle_data", 32'(mem_data), 32'd0);
            end
            if (sp_wr) begin
                if (exp_sp.size() > 0) begin
                    got_sp = exp_sp.pop_front();
                    check_eq("sp_new", sp_new, got_sp);
                end else begin
                    check_eq("sp_wr_unexpected", 32'(sp_wr), 32'd0);
                end
            end
            if (done || sp_wr) begin
                check_eq("done_with_sp_wr", 32'(done), 32'(sp_wr));
            end
            if (done) n_done++;
        end
    end

    // Count cycles from the next falling edge to first write and to done
    task automatic wait_seq(input int words, input string tag);
        int first_wr;
        int done_idx;
        int busy_cnt;
        first_wr = -1;
        done_idx = -1;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_wr && first_wr < 0) first_wr = i;
            if (busy) busy_cnt++;
            if (done) begin
                done_idx = i;
                break;
            end
        end
        check_eq({tag, "_first_wr"}, 32'(first_wr), 32'd1);
        check_eq({tag, "_done_lat"}, 32'(done_idx), 32'(words + 1));
        check_eq({tag, "_busy_cyc"}, 32'(busy_cnt), 32'(words + 1));
    endtask

    // Single-cycle request, inputs scrambled right after acceptance
    task automatic run_push(input logic [31:0] s, input logic [31:0] a,
                            input logic f, input logic [3:0] fl, input string tag);
        @(negedge clk);
        sp = s; push_addr = a; push_flags = f; flags_in = fl; push_req = 1'b1;
        expect_push(s, a, f, fl);
        @(posedge clk);
        #1;
        push_req = 1'b0;
        sp = ~s; push_addr = ~a; push_flags = ~f; flags_in = ~fl;
        wait_seq(f ? 3 : 2, tag);
    endtask

    initial begin
        // Reset state before any clock edge
        #2;
        check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_data", 32'(mem_data), 32'd0);
        check_eq("rst_sp_wr", 32'(sp_wr), 32'd0);
        check_eq("rst_sp_new", sp_new, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_push(32'h000F_FFFE, 32'h0012_3456, 1'b0, 4'h0, "plain");
        run_push(32'h000F_FFFE, 32'h0012_3456, 1'b1, 4'b1011, "flags");
        run_push(32'h0000_0001, 32'hCAFE_BABE, 1'b0, 4'h0, "wrap1");
        run_push(32'h0000_0000, 32'h89AB_CDEF, 1'b1, 4'h5, "wrap0");

        // Request raised during PUSH_LO and dropped before IDLE: ignored
        @(negedge clk);
        sp = 32'h0001_0000; push_addr = 32'h1111_2222; push_flags = 1'b0; push_req = 1'b1;
        expect_push(32'h0001_0000, 32'h1111_2222, 1'b0, 4'h0);
        fork
            wait_seq(2, "ignore");
            begin
                @(posedge clk); #1 push_req = 1'b0;
                @(posedge clk); #1;
                push_req = 1'b1; push_addr = 32'hDEAD_BEEF; sp = 32'h0000_0055;
                @(posedge clk);
                @(posedge clk); #1 push_req = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check_eq("ignore_idle_busy", 32'(busy), 32'd0);

        // Request raised during PUSH_LO and held: accepted after FINISH
        @(negedge clk);
        sp = 32'h0002_0000; push_addr = 32'h3333_4444; push_req = 1'b1;
        expect_push(32'h0002_0000, 32'h3333_4444, 1'b0, 4'h0);
        fork
            wait_seq(2, "held1");
            begin
                @(posedge clk); #1 push_req = 1'b0;
                @(posedge clk); #1;
                push_req = 1'b1; push_addr = 32'h5555_6666; sp = 32'h0003_0000;
                expect_push(32'h0003_0000, 32'h5555_6666, 1'b0, 4'h0);
            end
        join
        wait_seq(2, "held2");
        push_req = 1'b0;
        repeat (3) @(negedge clk);

        // Reset while the low word is on the bus
        @(negedge clk);
        sp = 32'h0004_0000; push_addr = 32'h7777_8888; push_req = 1'b1;
        expect_push(32'h0004_0000, 32'h7777_8888, 1'b0, 4'h0);
        @(posedge clk); #1 push_req = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check_eq("pre_abort_wr", 32'(mem_wr), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("abort_mem_wr", 32'(mem_wr), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_sp_wr", 32'(sp_wr), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        exp_wr.delete();
        exp_sp.delete();
        n_seq--;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        run_push(32'h0005_0000, 32'h9999_AAAA, 1'b1, 4'hC, "post_rst");

        // Back-to-back requests held high; SP changes between acceptances
        @(negedge clk);
        sp = 32'h0006_0010; push_addr = 32'hABCD_0001; push_flags = 1'b0; push_req = 1'b1;
        expect_push(32'h0006_0010, 32'hABCD_0001, 1'b0, 4'h0);
        fork
            wait_seq(2, "b2b1");
            begin
                @(posedge clk); #1;
                sp = 32'h0007_0020; push_addr = 32'hABCD_0002;
                expect_push(32'h0007_0020, 32'hABCD_0002, 1'b0, 4'h0);
            end
        join
        wait_seq(2, "b2b2");
        push_req = 1'b0;

        repeat (5) @(negedge clk);
        check_eq("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        check_eq("sp_queue_drained", 32'(exp_sp.size()), 32'd0);
        check_eq("done_pulses", 32'(n_done), 32'(n_seq));
        check_eq("final_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
